// File: rtl/p_regfile_pkg.sv
// Shared defaults and status-word bit layout for the register file with game mailboxes.
package p_regfile_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_ADDR_W     = 5;
   localparam int DEF_N_CH       = 2;
   localparam int DEF_CH_BASE    = 20;
   localparam int DEF_CH_STRIDE  = 5;
   localparam int DEF_STATUS_REG = 27;

   function automatic int st_in_new(input int k);
      return k;
   endfunction

   function automatic int st_out_valid(input int n_ch, input int k);
      return n_ch + k;
   endfunction

   function automatic int st_ovf(input int n_ch, input int k);
      return 2 * n_ch + k;
   endfunction

   // True when every mailbox and status index is distinct, nonzero and inside the file.
   function automatic bit mbox_layout_ok(input int n_ch, input int base, input int stride,
                                         input int status_reg, input int num_regs);
      int idx [0:16];
      int n;
      if (n_ch < 1 || n_ch > 8) return 1'b0;
      n = 0;
      for (int k = 0; k < n_ch; k++) begin
         idx[n]     = base + k * stride;
         idx[n + 1] = base + k * stride + 1;
         n += 2;
      end
      idx[n] = status_reg;
      n++;
      for (int i = 0; i < n; i++) begin
         if (idx[i] <= 0 || idx[i] >= num_regs) return 1'b0;
         for (int j = 0; j < i; j++)
            if (idx[i] == idx[j]) return 1'b0;
      end
      return 1'b1;
   endfunction

endpackage

// File: rtl/p_mbox_channel.sv
// One game mailbox channel: IN/OUT data registers plus in_new, out_valid and
// (with P_REGFILE_MBOX_OVF_EN) a sticky overflow flag.
module p_mbox_channel #(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              ctrl_reset,
   input  logic              out_write,
   input  logic [DATA_W-1:0] write_data,
   input  logic              clr_in_new,
`ifdef P_REGFILE_MBOX_OVF_EN
   input  logic              clr_ovf,
   output logic              ovf,
`endif
   input  logic [DATA_W-1:0] game_in_data,
   input  logic              game_in_valid,
   input  logic              game_out_ack,
   output logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] out_data,
   output logic              in_new,
   output logic              out_valid
);

   logic [DATA_W-1:0] in_data_reg;
   logic [DATA_W-1:0] out_data_reg;
   logic              in_new_reg, in_new_next;
   logic              out_valid_reg, out_valid_next;

   // Sets are applied after clears so a coincident set always wins.
   always_comb begin
      in_new_next = in_new_reg;
      if (clr_in_new)    in_new_next = 1'b0;
      if (game_in_valid) in_new_next = 1'b1;
      out_valid_next = out_valid_reg;
      if (game_out_ack)  out_valid_next = 1'b0;
      if (out_write)     out_valid_next = 1'b1;
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         in_data_reg   <= '0;
         out_data_reg  <= '0;
         in_new_reg    <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         in_new_reg    <= in_new_next;
         out_valid_reg <= out_valid_next;
         if (game_in_valid) in_data_reg  <= game_in_data;
         if (out_write)     out_data_reg <= write_data;
      end
   end

`ifdef P_REGFILE_MBOX_OVF_EN
   logic ovf_reg, ovf_next;

   always_comb begin
      ovf_next = ovf_reg;
      if (clr_ovf)                     ovf_next = 1'b0;
      if (game_in_valid && in_new_reg) ovf_next = 1'b1;
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) ovf_reg <= 1'b0;
      else            ovf_reg <= ovf_next;
   end

   assign ovf = ovf_reg;
`endif

   assign in_data   = in_data_reg;
   assign out_data  = out_data_reg;
   assign in_new    = in_new_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: rtl/p_regfile_mbox.sv
// CPU register file (2 comb reads with write bypass, 1 write) carrying N_CH handshaked
// game mailboxes and a W1C status register. Optional overflow flags: P_REGFILE_MBOX_OVF_EN.
module p_regfile_mbox
   import p_regfile_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int N_CH       = DEF_N_CH,
   parameter int CH_BASE    = DEF_CH_BASE,
   parameter int CH_STRIDE  = DEF_CH_STRIDE,
   parameter int STATUS_REG = DEF_STATUS_REG
) (
   input  logic                   clock,
   input  logic                   ctrl_reset,
   input  logic                   ctrl_writeEnable,
   input  logic [ADDR_W-1:0]      ctrl_writeReg,
   input  logic [ADDR_W-1:0]      ctrl_readRegA,
   input  logic [ADDR_W-1:0]      ctrl_readRegB,
   input  logic [DATA_W-1:0]      data_writeReg,
   output logic [DATA_W-1:0]      data_readRegA,
   output logic [DATA_W-1:0]      data_readRegB,
   input  logic [N_CH*DATA_W-1:0] game_in_data,
   input  logic [N_CH-1:0]        game_in_valid,
   output logic [N_CH-1:0]        game_in_busy,
   output logic [N_CH*DATA_W-1:0] game_out_data,
   output logic [N_CH-1:0]        game_out_valid,
   input  logic [N_CH-1:0]        game_out_ack
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   if (N_CH * 3 > DATA_W) begin : g_err_width
      $error("p_regfile_mbox: status word needs N_CH*3 <= DATA_W");
   end
   if (!mbox_layout_ok(N_CH, CH_BASE, CH_STRIDE, STATUS_REG, NUM_REGS)) begin : g_err_layout
      $error("p_regfile_mbox: mailbox/status indices overlap, are zero or out of range");
   end

   logic [DATA_W-1:0]            regs_reg [NUM_REGS];
   logic [N_CH-1:0][DATA_W-1:0]  ch_in_data;
   logic [N_CH-1:0][DATA_W-1:0]  ch_out_data;
   logic [N_CH-1:0]              ch_in_new;
   logic [N_CH-1:0]              ch_out_valid;
   logic [N_CH-1:0]              ch_out_write;
   logic [N_CH-1:0]              ch_clr_in_new;
   logic [DATA_W-1:0]            status_word;
   logic                         wr_status;
   logic                         wr_is_mbox;
   logic                         wr_general;
   logic [DATA_W-1:0]            rd_data [2];
`ifdef P_REGFILE_MBOX_OVF_EN
   logic [N_CH-1:0]              ch_ovf;
   logic [N_CH-1:0]              ch_clr_ovf;
`endif

   always_comb begin
      wr_status  = ctrl_writeEnable && (int'(ctrl_writeReg) == STATUS_REG);
      wr_is_mbox = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (int'(ctrl_writeReg) == CH_BASE + k * CH_STRIDE ||
             int'(ctrl_writeReg) == CH_BASE + k * CH_STRIDE + 1)
            wr_is_mbox = 1'b1;
      end
      wr_general = ctrl_writeEnable && (ctrl_writeReg != '0) && !wr_status && !wr_is_mbox;
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
      end else if (wr_general) begin
         regs_reg[ctrl_writeReg] <= data_writeReg;
      end
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      localparam int IN_IDX = CH_BASE + gi * CH_STRIDE;

      assign ch_out_write[gi]  = ctrl_writeEnable && (int'(ctrl_writeReg) == IN_IDX + 1);
      assign ch_clr_in_new[gi] = wr_status && data_writeReg[st_in_new(gi)];
`ifdef P_REGFILE_MBOX_OVF_EN
      assign ch_clr_ovf[gi]    = wr_status && data_writeReg[st_ovf(N_CH, gi)];
`endif

      p_mbox_channel #(.DATA_W(DATA_W)) u_ch (
         .clock        (clock),
         .ctrl_reset   (ctrl_reset),
         .out_write    (ch_out_write[gi]),
         .write_data   (data_writeReg),
         .clr_in_new   (ch_clr_in_new[gi]),
`ifdef P_REGFILE_MBOX_OVF_EN
         .clr_ovf      (ch_clr_ovf[gi]),
         .ovf          (ch_ovf[gi]),
`endif
         .game_in_data (game_in_data[gi*DATA_W +: DATA_W]),
         .game_in_valid(game_in_valid[gi]),
         .game_out_ack (game_out_ack[gi]),
         .in_data      (ch_in_data[gi]),
         .out_data     (ch_out_data[gi]),
         .in_new       (ch_in_new[gi]),
         .out_valid    (ch_out_valid[gi])
      );
   end

   always_comb begin
      status_word = '0;
      for (int k = 0; k < N_CH; k++) begin
         status_word[st_in_new(k)]          = ch_in_new[k];
         status_word[st_out_valid(N_CH, k)] = ch_out_valid[k];
`ifdef P_REGFILE_MBOX_OVF_EN
         status_word[st_ovf(N_CH, k)]       = ch_ovf[k];
`endif
      end
   end

   // IN_k and STATUS are not CPU-writable, so they never take the write bypass.
   always_comb begin : rd_mux
      logic [ADDR_W-1:0] a;
      logic              ro_hit;
      a      = '0;
      ro_hit = 1'b0;
      for (int p = 0; p < 2; p++) begin
         a          = (p == 0) ? ctrl_readRegA : ctrl_readRegB;
         rd_data[p] = regs_reg[a];
         ro_hit     = (int'(a) == STATUS_REG);
         for (int k = 0; k < N_CH; k++) begin
            if (int'(a) == CH_BASE + k * CH_STRIDE) begin
               rd_data[p] = ch_in_data[k];
               ro_hit     = 1'b1;
            end
            if (int'(a) == CH_BASE + k * CH_STRIDE + 1) rd_data[p] = ch_out_data[k];
         end
         if (int'(a) == STATUS_REG) rd_data[p] = status_word;
         if (ctrl_writeEnable && (ctrl_writeReg == a) && !ro_hit) rd_data[p] = data_writeReg;
         if (a == '0) rd_data[p] = '0;
      end
   end

   assign data_readRegA  = rd_data[0];
   assign data_readRegB  = rd_data[1];
   assign game_in_busy   = ch_in_new;
   assign game_out_valid = ch_out_valid;
   assign game_out_data  = ch_out_data;

endmodule

// File: tb/tb_p_regfile_mbox.sv
// Self-checking bench for p_regfile_mbox: directed literal checks, then random traffic
// compared every cycle against a behavioural mailbox model.
module tb_p_regfile_mbox;

   logic        clock = 1'b0;
   logic        ctrl_reset;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [4:0]  ctrl_readRegA;
   logic [4:0]  ctrl_readRegB;
   logic [31:0] data_writeReg;
   logic [31:0] data_readRegA;
   logic [31:0] data_readRegB;
   logic [63:0] game_in_data;
   logic [1:0]  game_in_valid;
   logic [1:0]  game_in_busy;
   logic [63:0] game_out_data;
   logic [1:0]  game_out_valid;
   logic [1:0]  game_out_ack;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   p_regfile_mbox #(
      .DATA_W(32), .ADDR_W(5), .N_CH(2), .CH_BASE(20), .CH_STRIDE(5), .STATUS_REG(27)
   ) dut (
      .clock           (clock),
      .ctrl_reset      (ctrl_reset),
      .ctrl_writeEnable(ctrl_writeEnable),
      .ctrl_writeReg   (ctrl_writeReg),
      .ctrl_readRegA   (ctrl_readRegA),
      .ctrl_readRegB   (ctrl_readRegB),
      .data_writeReg   (data_writeReg),
      .data_readRegA   (data_readRegA),
      .data_readRegB   (data_readRegB),
      .game_in_data    (game_in_data),
      .game_in_valid   (game_in_valid),
      .game_in_busy    (game_in_busy),
      .game_out_data   (game_out_data),
      .game_out_valid  (game_out_valid),
      .game_out_ack    (game_out_ack)
   );

   always #5 clock = ~clock;

   // Behavioural model state
   logic [31:0] m_regs [32];
   logic [31:0] m_in   [2];
   logic [31:0] m_out  [2];
   logic [1:0]  m_in_new, m_out_valid, m_ovf;

   function automatic int in_idx(input int k);
      return 20 + 5 * k;
   endfunction

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s = '0;
      s[1:0] = m_in_new;
      s[3:2] = m_out_valid;
      s[5:4] = m_ovf;
      return s;
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (ctrl_writeEnable && ctrl_writeReg == a && a != 20 && a != 25 && a != 27)
         return data_writeReg;
      for (int k = 0; k < 2; k++) begin
         if (int'(a) == in_idx(k))     return m_in[k];
         if (int'(a) == in_idx(k) + 1) return m_out[k];
      end
      if (a == 27) return m_status();
      return m_regs[a];
   endfunction

   always @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         for (int i = 0; i < 32; i++) m_regs[i] <= '0;
         for (int k = 0; k < 2; k++) begin
            m_in[k]  <= '0;
            m_out[k] <= '0;
         end
         m_in_new    <= '0;
         m_out_valid <= '0;
         m_ovf       <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (game_out_ack[k]) m_out_valid[k] <= 1'b0;
            if (ctrl_writeEnable && ctrl_writeReg == 5'd27) begin
               if (data_writeReg[k])     m_in_new[k] <= 1'b0;
               if (data_writeReg[4 + k]) m_ovf[k]    <= 1'b0;
            end
            if (game_in_valid[k]) begin
               m_in[k]     <= game_in_data[32*k +: 32];
               m_in_new[k] <= 1'b1;
`ifdef P_REGFILE_MBOX_OVF_EN
               if (m_in_new[k]) m_ovf[k] <= 1'b1;
`endif
            end
            if (ctrl_writeEnable && int'(ctrl_writeReg) == in_idx(k) + 1) begin
               m_out[k]       <= data_writeReg;
               m_out_valid[k] <= 1'b1;
            end
         end
         if (ctrl_writeEnable && ctrl_writeReg != 0 && ctrl_writeReg != 20 &&
             ctrl_writeReg != 21 && ctrl_writeReg != 25 && ctrl_writeReg != 26 &&
             ctrl_writeReg != 27)
            m_regs[ctrl_writeReg] <= data_writeReg;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Per-cycle comparison against the model
   always @(negedge clock) begin
      if (chk_en) begin
         check("model_rdA",   64'(data_readRegA), 64'(exp_read(ctrl_readRegA)));
         check("model_rdB",   64'(data_readRegB), 64'(exp_read(ctrl_readRegB)));
         check("model_busy",  64'(game_in_busy), 64'(m_in_new));
         check("model_oval",  64'(game_out_valid), 64'(m_out_valid));
         check("model_odata", game_out_data, {m_out[1], m_out[0]});
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg    = '0;
      ctrl_readRegA    = '0;
      ctrl_readRegB    = '0;
      data_writeReg    = '0;
      game_in_data     = '0;
      game_in_valid    = '0;
      game_out_ack     = '0;
   endtask

   function automatic logic [4:0] rnd_addr();
      case ($urandom_range(0, 9))
         0: return 5'd0;
         1: return 5'd20;
         2: return 5'd21;
         3: return 5'd25;
         4: return 5'd26;
         5: return 5'd27;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   initial begin
      idle();
      ctrl_reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 ctrl_reset = 1'b0;
      chk_en = 1'b1;

      // reset state
      ctrl_readRegA = 5'd3;
      ctrl_readRegB = 5'd27;
      #1;
      check("rst_rdA", 64'(data_readRegA), 64'h0);
      check("rst_status", 64'(data_readRegB), 64'h0);
      check("rst_oval", 64'(game_out_valid), 64'h0);
      check("rst_busy", 64'(game_in_busy), 64'h0);

      // write-through bypass and register 0
      ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'hDEADBEEF;
      #1 check("bypass_same_cycle", 64'(data_readRegA), 64'hDEADBEEF);
      step(); ctrl_writeEnable = 1'b0;
      #1 check("reg3_stored", 64'(data_readRegA), 64'hDEADBEEF);
      ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'h1; ctrl_readRegA = 5'd0;
      #1 check("reg0_bypass", 64'(data_readRegA), 64'h0);
      step(); ctrl_writeEnable = 1'b0;
      #1 check("reg0_stored", 64'(data_readRegA), 64'h0);

      // input channel 1
      idle();
      game_in_valid = 2'b10; game_in_data = {32'h0000_0015, 32'h0};
      step(); idle();
      ctrl_readRegA = 5'd25; ctrl_readRegB = 5'd27;
      #1;
      check("in1_data", 64'(data_readRegA), 64'd21);
      check("in1_status", 64'(data_readRegB), 64'h2);
      check("in1_busy", 64'(game_in_busy), 64'h2);
      ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd27; data_writeReg = 32'h2;
      #1 check("status_no_bypass", 64'(data_readRegB), 64'h2);
      step(); ctrl_writeEnable = 1'b0;
      #1;
      check("in1_w1c", 64'(data_readRegB), 64'h0);
      check("in1_busy_clr", 64'(game_in_busy), 64'h0);
      ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd25; data_writeReg = 32'hFFFF;
      #1 check("in1_no_bypass", 64'(data_readRegA), 64'd21);
      step(); ctrl_writeEnable = 1'b0;
      #1 check("in1_readonly", 64'(data_readRegA), 64'd21);

      // output channel 0
      idle();
      ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd21; data_writeReg = 32'h0003_0004;
      step(); ctrl_writeEnable = 1'b0; ctrl_readRegA = 5'd21; ctrl_readRegB = 5'd27;
      #1;
      check("out0_valid", 64'(game_out_valid), 64'h1);
      check("out0_data", 64'(game_out_data[31:0]), 64'h0003_0004);
      check("out0_status", 64'(data_readRegB), 64'h4);
      game_out_ack = 2'b01;
      step(); game_out_ack = 2'b00;
      #1;
      check("out0_ack_clr", 64'(game_out_valid), 64'h0);
      check("out0_data_stable", 64'(game_out_data[31:0]), 64'h0003_0004);
      ctrl_writeEnable = 1'b1; data_writeReg = 32'h111;
      step(); data_writeReg = 32'h777; game_out_ack = 2'b01;
      step(); ctrl_writeEnable = 1'b0; game_out_ack = 2'b00;
      #1;
      check("out0_write_wins", 64'(game_out_valid), 64'h1);
      check("out0_write_data", 64'(game_out_data[31:0]), 64'h777);

      // reset mid-handshake
      ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd21; data_writeReg = 32'h5;
      step(); ctrl_writeEnable = 1'b0; ctrl_readRegA = 5'd21; ctrl_readRegB = 5'd3;
      #1;
      check("pre_rst_out0", 64'(data_readRegA), 64'h5);
      check("pre_rst_oval", 64'(game_out_valid), 64'h1);
      ctrl_reset = 1'b1;
      #1;
      check("rst_mid_rdA", 64'(data_readRegA), 64'h0);
      check("rst_mid_rdB", 64'(data_readRegB), 64'h0);
      check("rst_mid_oval", 64'(game_out_valid), 64'h0);
      step(); ctrl_reset = 1'b0;

      // back-to-back loads without clearing
      idle();
      game_in_valid = 2'b01; game_in_data = {32'h0, 32'hA};
      step(); game_in_data = {32'h0, 32'hB};
      step(); idle();
      ctrl_readRegA = 5'd20; ctrl_readRegB = 5'd27;
      #1;
      check("ovf_data", 64'(data_readRegA), 64'hB);
`ifdef P_REGFILE_MBOX_OVF_EN
      check("ovf_status", 64'(data_readRegB), 64'h11);
`else
      check("ovf_status", 64'(data_readRegB), 64'h01);
`endif
      ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd27; data_writeReg = 32'h10;
      step(); ctrl_writeEnable = 1'b0;
      #1 check("ovf_w1c", 64'(data_readRegB), 64'h01);

      // randomized traffic, checked by the per-cycle compare process
      for (int c = 0; c < 3000; c++) begin
         step();
         ctrl_reset       = ($urandom_range(0, 299) == 0);
         ctrl_writeEnable = $urandom_range(0, 1) == 1;
         ctrl_writeReg    = rnd_addr();
         ctrl_readRegA    = ($urandom_range(0, 3) == 0) ? ctrl_writeReg : rnd_addr();
         ctrl_readRegB    = rnd_addr();
         data_writeReg    = $urandom();
         game_in_data     = {$urandom(), $urandom()};
         game_in_valid    = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         game_out_ack     = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      end
      step();
      ctrl_reset = 1'b0;
      idle();
      step();
      chk_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
